alarm_scheduler: RTL and testbench

ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

---
 rtl/watch_pkg.sv | 22 ++
 rtl/edge_detect.sv | 23 ++
 rtl/alarm_scheduler.sv | 142 ++++++++++++++
 tb/tb_alarm_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared alarm scheduler types and defaults.
// State encoding plus the counter-width helper.
package watch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    localparam int unsigned DEF_RING_SECS   = 60;
    localparam int unsigned DEF_SNOOZE_SECS = 300;
    localparam int unsigned DEF_MAX_SNOOZE  = 3;

    function automatic int unsigned sec_width(
        input int unsigned a,
        input int unsigned b
    );
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: registered history, pulse
// is high while the level is high and history is low.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic prev;

    // Remember last cycle's level; reset clears history.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign pulse = level & ~prev;

endmodule

// File: rtl/alarm_scheduler.sv
// Alarm ring / snooze / timeout controller.
// All outputs are registered from a single FSM block.
module alarm_scheduler
    import watch_pkg::*;
#(
    parameter int unsigned RING_SECS   = DEF_RING_SECS,
    parameter int unsigned SNOOZE_SECS = DEF_SNOOZE_SECS,
    parameter int unsigned MAX_SNOOZE  = DEF_MAX_SNOOZE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       alarm_match,
    input  logic       alarm_enable,
    input  logic       btn_snooze,
    input  logic       btn_stop,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] snooze_cnt,
    output logic       missed
);

    localparam int unsigned SW = sec_width(RING_SECS, SNOOZE_SECS);
    localparam logic [SW-1:0] RING_LIM = SW'(RING_SECS);
    localparam logic [SW-1:0] SNZ_LIM  = SW'(SNOOZE_SECS);
    localparam logic [SW-1:0] ONE      = SW'(1);
    localparam logic [1:0]    SNZ_MAX  = 2'(MAX_SNOOZE);

    state_t        state;
    logic [SW-1:0] sec_cnt;
    logic [SW-1:0] sec_nxt;
    logic          match_edge;
    logic          snooze_edge;
    logic          stop_edge;

    edge_detect u_match (
        .clk   (clk),
        .reset (reset),
        .level (alarm_match),
        .pulse (match_edge)
    );

    edge_detect u_snooze (
        .clk   (clk),
        .reset (reset),
        .level (btn_snooze),
        .pulse (snooze_edge)
    );

    edge_detect u_stop (
        .clk   (clk),
        .reset (reset),
        .level (btn_stop),
        .pulse (stop_edge)
    );

    assign sec_nxt = sec_cnt + ONE;

    // Main FSM: buttons beat timeouts, stop beats snooze.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sec_cnt    <= '0;
            buzzer     <= 1'b0;
            ringing    <= 1'b0;
            snoozing   <= 1'b0;
            snooze_cnt <= 2'd0;
            missed     <= 1'b0;
        end else if (!alarm_enable) begin
            state    <= IDLE;
            sec_cnt  <= '0;
            buzzer   <= 1'b0;
            ringing  <= 1'b0;
            snoozing <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (match_edge) begin
                        state      <= RING;
                        sec_cnt    <= '0;
                        snooze_cnt <= 2'd0;
                        missed     <= 1'b0;
                        buzzer     <= 1'b1;
                        ringing    <= 1'b1;
                    end
                end
                RING: begin
                    if (stop_edge) begin
                        state   <= IDLE;
                        sec_cnt <= '0;
                        buzzer  <= 1'b0;
                        ringing <= 1'b0;
                    end else if (snooze_edge && (snooze_cnt < SNZ_MAX)) begin
                        state      <= SNOOZE;
                        sec_cnt    <= '0;
                        snooze_cnt <= snooze_cnt + 2'd1;
                        buzzer     <= 1'b0;
                        ringing    <= 1'b0;
                        snoozing   <= 1'b1;
                    end else if (tick_1hz) begin
                        if (sec_nxt == RING_LIM) begin
                            state   <= IDLE;
                            sec_cnt <= '0;
                            buzzer  <= 1'b0;
                            ringing <= 1'b0;
                            missed  <= 1'b1;
                        end else begin
                            sec_cnt <= sec_nxt;
                            buzzer  <= ~buzzer;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop_edge) begin
                        state    <= IDLE;
                        sec_cnt  <= '0;
                        snoozing <= 1'b0;
                    end else if (tick_1hz) begin
                        if (sec_nxt == SNZ_LIM) begin
                            state    <= RING;
                            sec_cnt  <= '0;
                            buzzer   <= 1'b1;
                            ringing  <= 1'b1;
                            snoozing <= 1'b0;
                        end else begin
                            sec_cnt <= sec_nxt;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    sec_cnt  <= '0;
                    buzzer   <= 1'b0;
                    ringing  <= 1'b0;
                    snoozing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_scheduler.sv
// Bench for alarm_scheduler: vector table, directed
// corner sequences, then random traffic vs a model.
module tb_alarm_scheduler;

    localparam int RS = 4;
    localparam int SS = 2;
    localparam int MS = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       alarm_match = 1'b0;
    logic       alarm_enable = 1'b0;
    logic       btn_snooze = 1'b0;
    logic       btn_stop = 1'b0;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [1:0] snooze_cnt;
    logic       missed;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alarm_scheduler #(
        .RING_SECS   (RS),
        .SNOOZE_SECS (SS),
        .MAX_SNOOZE  (MS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tick_1hz     (tick_1hz),
        .alarm_match  (alarm_match),
        .alarm_enable (alarm_enable),
        .btn_snooze   (btn_snooze),
        .btn_stop     (btn_stop),
        .buzzer       (buzzer),
        .ringing      (ringing),
        .snoozing     (snoozing),
        .snooze_cnt   (snooze_cnt),
        .missed       (missed)
    );

    // Reference model: mode plus seconds elapsed in the
    // current phase; buzzer is on for even ring seconds.
    localparam int M_IDLE = 0;
    localparam int M_RING = 1;
    localparam int M_SNZ  = 2;

    int md_mode = M_IDLE;
    int md_secs = 0;
    int md_cnt  = 0;
    bit md_miss = 1'b0;
    bit pm = 1'b0;
    bit psn = 1'b0;
    bit pst = 1'b0;

    function automatic void model_step(bit r, bit en, bit m,
                                       bit sn, bit st, bit tk);
        bit em, esn, est;
        if (r) begin
            md_mode = M_IDLE;
            md_secs = 0;
            md_cnt  = 0;
            md_miss = 1'b0;
            pm = 1'b0;
            psn = 1'b0;
            pst = 1'b0;
            return;
        end
        em  = m && !pm;
        esn = sn && !psn;
        est = st && !pst;
        pm  = m;
        psn = sn;
        pst = st;
        if (!en) begin
            md_mode = M_IDLE;
            md_secs = 0;
        end else if (md_mode == M_IDLE) begin
            if (em) begin
                md_mode = M_RING;
                md_secs = 0;
                md_cnt  = 0;
                md_miss = 1'b0;
            end
        end else if (md_mode == M_RING) begin
            if (est) begin
                md_mode = M_IDLE;
            end else if (esn && md_cnt < MS) begin
                md_mode = M_SNZ;
                md_cnt  = md_cnt + 1;
                md_secs = 0;
            end else if (tk) begin
                md_secs = md_secs + 1;
                if (md_secs >= RS) begin
                    md_mode = M_IDLE;
                    md_miss = 1'b1;
                end
            end
        end else begin
            if (est) begin
                md_mode = M_IDLE;
            end else if (tk) begin
                md_secs = md_secs + 1;
                if (md_secs >= SS) begin
                    md_mode = M_RING;
                    md_secs = 0;
                end
            end
        end
    endfunction

    function automatic logic [5:0] model_out();
        logic rg;
        rg = (md_mode == M_RING);
        return {rg, md_mode == M_SNZ, rg && (md_secs % 2 == 0),
                2'(md_cnt), md_miss};
    endfunction

    task automatic drive(input bit r, input bit en, input bit m,
                         input bit sn, input bit st, input bit tk);
        @(negedge clk);
        reset        = r;
        alarm_enable = en;
        alarm_match  = m;
        btn_snooze   = sn;
        btn_stop     = st;
        tick_1hz     = tk;
        @(posedge clk);
        model_step(r, en, m, sn, st, tk);
        #1;
    endtask

    task automatic check(input string tag, input logic [5:0] exp);
        logic [5:0] act;
        act = {ringing, snoozing, buzzer, snooze_cnt, missed};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got ring/snz/buz/cnt/miss=%b need %b",
                     tag, act, exp);
        end
    endtask

    typedef struct packed {
        logic       r;
        logic       en;
        logic       m;
        logic       sn;
        logic       st;
        logic       tk;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl [17];

    initial begin
        // exp = {ringing, snoozing, buzzer, snooze_cnt[1:0], missed}
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b101000};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'b100000};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'b101000};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000000};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b101000};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'b000000};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b101000};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'b010010};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'b010010};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'b101010};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b101010};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000010};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000010};

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].r, tbl[i].en, tbl[i].m,
                  tbl[i].sn, tbl[i].st, tbl[i].tk);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Unanswered ring times out on the RS-th tick.
        drive(1, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        for (int t = 0; t < 3; t++) drive(0, 1, 1, 0, 0, 1);
        check("ring_t3", 6'b100000);
        drive(0, 1, 1, 0, 0, 1);
        check("timeout", 6'b000001);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        check("missed_clr", 6'b101000);

        // Three snoozes, each re-ringing after SS ticks.
        for (int k = 1; k <= 3; k++) begin
            drive(0, 1, 1, 1, 0, 0);
            check($sformatf("snz%0d", k),
                  {1'b0, 1'b1, 1'b0, 2'(k), 1'b0});
            drive(0, 1, 1, 0, 0, 1);
            drive(0, 1, 1, 0, 0, 1);
            check($sformatf("rering%0d", k),
                  {1'b1, 1'b0, 1'b1, 2'(k), 1'b0});
        end
        drive(0, 1, 1, 1, 0, 0);
        check("snz4_ign", 6'b101110);
        for (int t = 0; t < 3; t++) drive(0, 1, 1, 0, 0, 1);
        drive(0, 1, 1, 0, 1, 1);
        check("stop_beats_to", 6'b000110);

        // Held match does not re-trigger after a stop.
        drive(0, 1, 0, 0, 0, 0);
        for (int c = 0; c < 10; c++) drive(0, 1, 1, 0, (c == 3), 0);
        check("hold_no_retrig", 6'b000000);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 0);
        check("snz_again", 6'b010010);
        drive(0, 0, 1, 0, 0, 0);
        check("en_drop_snz", 6'b000010);

        // Reset mid-ring, match still high re-rings.
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        check("ring_pre_rst", 6'b101000);
        drive(1, 1, 1, 0, 0, 0);
        check("rst_mid", 6'b000000);
        drive(0, 1, 1, 0, 0, 0);
        check("rst_rering", 6'b101000);

        // Random traffic against the reference model.
        begin
            bit m, en, sn, st, tk, r;
            m = 1'b0;
            sn = 1'b0;
            st = 1'b0;
            drive(1, 1, 0, 0, 0, 0);
            for (int n = 0; n < 4000; n++) begin
                if ($urandom_range(7) == 0) m = !m;
                if ($urandom_range(5) == 0) sn = !sn;
                if ($urandom_range(9) == 0) st = !st;
                en = ($urandom_range(39) != 0);
                tk = ($urandom_range(2) == 0);
                r  = ($urandom_range(299) == 0);
                drive(r, en, m, sn, st, tk);
                check($sformatf("rand%0d", n), model_out());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
